vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator for the VGA path, downstream of the pixel-clock counter/divider.
//  Turns a per-pixel enable into nested horizontal/vertical counters.
//  Drives hsync, vsync, display-enable, pixel coordinates and line/frame strobes.
//  Consumers: pixel/colour logic and the VGA output pins.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  HS_POL    0    hsync active level (0 = active-low)
//  VS_POL    0    vsync active level (0 = active-low)
//  CNT_W     10   counter width; 2^CNT_W >= H_TOTAL and V_TOTAL
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      reset; asynchronous, active-low
//  pix_en       in   1      one-clk pixel tick from upstream counter; advances the raster
//  hsync        out  1      horizontal sync, polarity per HS_POL
//  vsync        out  1      vertical sync, polarity per VS_POL
//  de           out  1      1 while in the visible region
//  x            out  CNT_W  current horizontal count, 0..H_TOTAL-1
//  y            out  CNT_W  current vertical count, 0..V_TOTAL-1
//  line_start   out  1      one-clk pulse on entry to x==0
//  frame_start  out  1      one-clk pulse on entry to (x,y)==(0,0)
//  rgb          out  12     {R4,G4,B4}; present only with VGA_TEST_PATTERN_EN
// BEHAVIOUR
//  - Derived totals: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
//  - Reset values:
//    - x = H_TOTAL-1, y = V_TOTAL-1.
//    - hsync/vsync at their inactive level; de = 0.
//    - line_start = 0, frame_start = 0, rgb = 0.
//    - Effect: the first pix_en after reset lands on (0,0).
//  - All outputs are registered and update only on a clk edge where pix_en = 1.
//  - Strobes are the exception: line_start/frame_start = 1 only on the clk where the
//    update enters the relevant position; 0 on every other clk.
//  - Advance on pix_en:
//    - x == H_TOTAL-1: x wraps to 0.
//    - At the same time y wraps to 0 if y == V_TOTAL-1, else y increments.
//    - Otherwise x increments and y holds.
//  - Decode (in the same register stage, zero latency relative to x/y):
//    - de = (x < H_ACTIVE) && (y < V_ACTIVE).
//    - hsync active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
//    - vsync active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491); spans whole lines.
//  - pix_en = 0: every output holds; no wrap, no strobe.
//  - rst_n asserted mid-frame: immediate return to reset values, no partial line completed.
//  - Counter arithmetic is unsigned CNT_W; the x/y range is guaranteed by the wrap rules
//    (no overflow path).
// CONFIGURATION
//  - VGA_TEST_PATTERN_EN defined:
//    - rgb exists: 8 vertical colour bars, bar index = x / (H_ACTIVE/8).
//    - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
//    - Each channel is 4'hF or 4'h0; rgb = 0 whenever de = 0.
//    - Registered with x/y.
//  - VGA_TEST_PATTERN_EN undefined: rgb port and its logic absent; all other behaviour identical.
// TESTING
//  - Reset, pix_en=1 every clk -> 1st clk x=0,y=0,frame_start=1,line_start=1,de=1;
//    x=656 hsync=0; x=752 hsync=1.
//  - Run 1 frame -> line_start every 800 pix_en; 525 per frame; vsync=0 exactly on y=490,491;
//    de high 307200 ticks.
//  - pix_en 1-in-4 clks -> outputs change only after pix_en clks; strobes 1 clk wide; totals unchanged.
//  - Reset at x=300,y=200 -> next clk x=799,y=524,de=0,hsync=vsync=1; next pix_en gives (0,0).
//  - Wrap (799,524)+pix_en -> (0,0) with frame_start=1; (799,10)+pix_en -> (0,11), line_start only.
//  - VGA_TEST_PATTERN_EN: x=0 rgb=FFF, x=80 rgb=FF0, x=639 rgb=000, x=700 rgb=000 (de=0).

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: nested x/y counters advanced by pix_en, with registered sync/de/strobe decode.
// Optional colour-bar test pattern on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_sync_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CNT_W    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_en,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             line_start,
   output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
   ,
   output logic [11:0]      rgb
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] x_nxt;
   logic [CNT_W-1:0] y_nxt;
   logic             line_end;
   logic             frame_end;
   logic             de_nxt;
   logic             hs_act;
   logic             vs_act;

   // Decode is done on the next position so the registered outputs line up with x/y.
   always_comb begin
      line_end  = (x == H_LAST);
      frame_end = line_end && (y == V_LAST);
      x_nxt     = x + CNT_W'(1);
      y_nxt     = y;
      if (line_end) begin
         x_nxt = '0;
         y_nxt = (y == V_LAST) ? '0 : y + CNT_W'(1);
      end
      de_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
      hs_act = (x_nxt >= HS_START) && (x_nxt < HS_END);
      vs_act = (y_nxt >= VS_START) && (y_nxt < VS_END);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x           <= H_LAST;
         y           <= V_LAST;
         de          <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_en && line_end;
         frame_start <= pix_en && frame_end;
         if (pix_en) begin
            x     <= x_nxt;
            y     <= y_nxt;
            de    <= de_nxt;
            hsync <= hs_act ? HS_POL : ~HS_POL;
            vsync <= vs_act ? VS_POL : ~VS_POL;
         end
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

   logic [CNT_W-1:0] bar_idx;
   logic [11:0]      bar_rgb;

   // Eight equal-width bars: white, yellow, cyan, green, magenta, red, blue, black.
   always_comb begin
      bar_idx = x_nxt / BAR_W;
      case (bar_idx)
         CNT_W'(0): bar_rgb = 12'hFFF;
         CNT_W'(1): bar_rgb = 12'hFF0;
         CNT_W'(2): bar_rgb = 12'h0FF;
         CNT_W'(3): bar_rgb = 12'h0F0;
         CNT_W'(4): bar_rgb = 12'hF0F;
         CNT_W'(5): bar_rgb = 12'hF00;
         CNT_W'(6): bar_rgb = 12'h00F;
         default:   bar_rgb = 12'h000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb <= 12'h000;
      end else if (pix_en) begin
         rgb <= de_nxt ? bar_rgb : 12'h000;
      end
   end
`endif

endmodule
